traffic_light_ctrl: RTL and testbench
=====================================

# traffic_light_ctrl

Parametrised single-module successor to the highway/country-road controller pair. One Moore FSM owns both road light outputs, so the two light outputs cannot be driven by separate sources. Compared with the current controller, it adds:
- configurable timer widths;
- an all-red clearance phase;
- a synchronised country-road sensor;
- a maintenance flash mode.

It sits directly under the intersection top level, driving the two lamp buses.

## Interface
Parameters:
- LONG_W, 7, width of Timeout (highway min-green / country max-green, in cycles)
- SHORT_W, 4, width of timeout (yellow duration, in cycles)
- CLR_CYCLES, 2, all-red clearance length in cycles (≥1)
- FLASH_HALF, 4, flash half-period in cycles (≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- sensor_c  in  1  country-road vehicle sensor, asynchronous, level
- Timeout  in  LONG_W  long phase duration; 0 treated as 1
- timeout  in  SHORT_W  yellow duration; 0 treated as 1
- flash_mode  in  1  maintenance flash request, level, synchronous to clk
- highway_light  out  3  {red, yellow, green}
- country_light  out  3  {red, yellow, green}
- state_o  out  3  current state code, for debug

## Operation
- Sensor synchroniser: sensor_c passes through a 2-flop synchroniser to give s_sync. The FSM uses only s_sync.
- Phase counter `elapsed`:
  - Width is max(LONG_W, SHORT_W, clog2(CLR_CYCLES), clog2(FLASH_HALF)).
  - Cleared to 0 on every state change; otherwise increments each cycle and saturates at all-ones.
  - A state has "expired" when `elapsed` ≥ dur−1, where dur is the effective duration for that state.
  - Timeout and timeout are compared live (quasi-static inputs). They are not latched.
- States, with state_o code and lights:
  - HG (0): highway 001, country 100.
  - HY (1): highway 010, country 100.
  - AR1 (2): highway 100, country 100.
  - CG (3): highway 100, country 001.
  - CY (4): highway 100, country 010.
  - AR2 (5): highway 100, country 100.
  - FL (6): highway 0y0, country r00, where y = r = the blink phase.
- Transitions, evaluated every rising edge:
  - HG → HY: expired(Timeout) and (s_sync or flash_mode).
  - HY → AR1: expired(timeout).
  - AR1 → FL if flash_mode, else → CG, when expired(CLR_CYCLES).
  - CG → CY: !s_sync, or flash_mode, or expired(Timeout). Minimum CG length is 1 cycle.
  - CY → AR2: expired(timeout).
  - AR2 → FL if flash_mode, else → HG, when expired(CLR_CYCLES).
  - FL → AR2: !flash_mode. Flash is always exited through a full all-red clearance.
- Safety rules:
  - Green or yellow is never shown on both roads at once.
  - Every green-to-opposite-green path passes through yellow then all-red.
  - Any illegal state code (7) goes to AR2 on the next edge.
- Flash:
  - A blink toggle is set to 1 on FL entry.
  - It inverts each time `elapsed` reaches FLASH_HALF−1; `elapsed` is cleared on each toggle.

## Timing
- Reset (reset=0) takes effect immediately and asynchronously:
  - state = HG, elapsed = 0, synchroniser flops = 0, blink = 0.
  - Outputs: highway_light = 001, country_light = 100, state_o = 0.
- Reset asserted mid-phase aborts that phase at once, with no yellow.
- Outputs are decoded from the state register only (Moore). Lights change on the same edge as the state.
- Sensor latency: a sensor_c edge reaches s_sync 2 edges later. It can affect the state at the 3rd edge.
- State lengths:
  - HG lasts exactly Timeout cycles when s_sync is already 1 at expiry. Otherwise HG holds until s_sync rises.
  - HY and CY each last exactly timeout cycles.
  - AR1 and AR2 each last exactly CLR_CYCLES cycles.
  - CG lasts min(Timeout, cycles until the first edge with s_sync=0 evaluated in CG).
- Simultaneous events:
  - In CG, flash_mode and Timeout expiry together give a single transition to CY.
  - In AR states, flash_mode takes priority over entering green.

## Test plan
- Reset, hold sensor_c=0, Timeout=10, timeout=3 for 100 cycles → highway_light=001 and country_light=100 on every cycle; state_o=0.
- sensor_c=1 from the first cycle after reset release, Timeout=10, timeout=3, CLR_CYCLES=2 → HG for 10 cycles, HY 3, AR1 2, then CG with country_light=001 for 10 cycles, CY 3, AR2 2, back to HG.
- In CG, drop sensor_c to 0 after 4 CG cycles → CY entered exactly 3 edges after the drop (2 synchroniser edges plus 1 FSM edge); CY lasts 3 cycles.
- Timeout=0, timeout=0, sensor_c=1 → every timed state lasts exactly 1 cycle; the sequence HG, HY, AR1, CG, CY, AR2 repeats. At no time do both outputs show a non-red lamp.
- Assert flash_mode during HG (after expiry) → HY 3 cycles, AR1 2 cycles, then FL with highway 010/000 and country 100/000 alternating every 4 cycles. Deassert flash_mode → AR2 for 2 cycles, then HG.
- Assert reset low in the middle of CY → outputs go to highway 001 / country 100 with no clock edge. Release → HG timing restarts from elapsed=0.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
// Purpose : highway / country-road intersection controller with all-red clearance and maintenance flash.
// Latency : lamps are decoded from the state register; the sensor reaches the FSM after 2 synchroniser edges.
// Backpressure : none; a free-running Moore FSM whose inputs are levels sampled every cycle.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset (forces HG, all counters cleared)
//   sensor_c       country-road vehicle sensor, asynchronous level
//   Timeout        highway minimum green / country maximum green in cycles (0 behaves as 1)
//   timeout        yellow duration in cycles (0 behaves as 1)
//   flash_mode     maintenance flash request, level, synchronous to clk
//   highway_light  {red, yellow, green} for the highway
//   country_light  {red, yellow, green} for the country road
//   state_o        current state code, debug only
module traffic_light_ctrl #(
  parameter int LONG_W     = 7,
  parameter int SHORT_W    = 4,
  parameter int CLR_CYCLES = 2,
  parameter int FLASH_HALF = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sensor_c,
  input  logic [LONG_W-1:0]  Timeout,
  input  logic [SHORT_W-1:0] timeout,
  input  logic               flash_mode,
  output logic [2:0]         highway_light,
  output logic [2:0]         country_light,
  output logic [2:0]         state_o
);

  // The phase counter must be wide enough to reach every duration it is
  // compared against: both timer inputs and both fixed-length phases.
  localparam int CLR_W = $clog2(CLR_CYCLES);
  localparam int FLS_W = $clog2(FLASH_HALF);
  localparam int MAX_A = (LONG_W > SHORT_W) ? LONG_W : SHORT_W;
  localparam int MAX_B = (CLR_W > FLS_W) ? CLR_W : FLS_W;
  localparam int CNT_W = (MAX_A > MAX_B) ? MAX_A : MAX_B;

  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF - 1);

  // State codes are visible on state_o, so the encoding is fixed.
  typedef enum logic [2:0] {
    ST_HG  = 3'd0,
    ST_HY  = 3'd1,
    ST_AR1 = 3'd2,
    ST_CG  = 3'd3,
    ST_CY  = 3'd4,
    ST_AR2 = 3'd5,
    ST_FL  = 3'd6
  } state_t;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  localparam lamp_t LAMP_RED    = '{red: 1'b1, yellow: 1'b0, green: 1'b0};
  localparam lamp_t LAMP_YELLOW = '{red: 1'b0, yellow: 1'b1, green: 1'b0};
  localparam lamp_t LAMP_GREEN  = '{red: 1'b0, yellow: 1'b0, green: 1'b1};

  state_t            state_q;
  state_t            state_nxt;
  logic              sync_meta;
  logic              s_sync;
  logic [CNT_W-1:0]  elapsed;
  logic              blink;
  logic [CNT_W-1:0]  long_last;
  logic [CNT_W-1:0]  short_last;
  logic              long_exp;
  logic              short_exp;
  logic              clr_exp;
  logic              flash_tick;
  logic              state_chg;
  lamp_t             hw_lamp;
  lamp_t             cr_lamp;

  // ------------------------------------------------------------------
  // Sensor synchroniser: sensor_c is a raw field input, so it only ever
  // reaches the FSM through two flops.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      s_sync    <= 1'b0;
    end else begin
      sync_meta <= sensor_c;
      s_sync    <= sync_meta;
    end
  end

  // ------------------------------------------------------------------
  // Expiry compares. A phase of length dur ends on the edge where the
  // counter holds dur-1; a zero-length request is stretched to one cycle.
  // The timer inputs are compared live, never captured.
  // ------------------------------------------------------------------
  assign long_last  = (Timeout == '0) ? '0 : (CNT_W'(Timeout) - CNT_W'(1));
  assign short_last = (timeout == '0) ? '0 : (CNT_W'(timeout) - CNT_W'(1));

  assign long_exp   = (elapsed >= long_last);
  assign short_exp  = (elapsed >= short_last);
  assign clr_exp    = (elapsed >= CLR_LAST);
  assign flash_tick = (elapsed >= FLASH_LAST);

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_HG;
    end else begin
      state_q <= state_nxt;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      // Highway keeps green until its minimum has elapsed AND there is a
      // reason to leave (waiting car or a flash request).
      ST_HG: begin
        if (long_exp && (s_sync || flash_mode)) begin
          state_nxt = ST_HY;
        end
      end
      ST_HY: begin
        if (short_exp) begin
          state_nxt = ST_AR1;
        end
      end
      // Flash is checked before green so a maintenance request never
      // hands out a fresh green.
      ST_AR1: begin
        if (clr_exp) begin
          state_nxt = flash_mode ? ST_FL : ST_CG;
        end
      end
      // Country green ends as soon as the road is empty, on a flash
      // request, or at the maximum green; any one alone is enough.
      ST_CG: begin
        if (!s_sync || flash_mode || long_exp) begin
          state_nxt = ST_CY;
        end
      end
      ST_CY: begin
        if (short_exp) begin
          state_nxt = ST_AR2;
        end
      end
      ST_AR2: begin
        if (clr_exp) begin
          state_nxt = flash_mode ? ST_FL : ST_HG;
        end
      end
      // Leaving flash always goes through a full all-red clearance.
      ST_FL: begin
        if (!flash_mode) begin
          state_nxt = ST_AR2;
        end
      end
      // Unreachable code 7: recover through all-red.
      default: begin
        state_nxt = ST_AR2;
      end
    endcase
  end

  assign state_chg = (state_nxt != state_q);

  // ------------------------------------------------------------------
  // Phase counter. Restarts on every state change; in FL it also restarts
  // at each blink toggle so it measures half-periods. Saturates so a long
  // HG hold keeps reporting "expired".
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      elapsed <= '0;
    end else if (state_chg || ((state_q == ST_FL) && flash_tick)) begin
      elapsed <= '0;
    end else if (elapsed != '1) begin
      elapsed <= elapsed + CNT_W'(1);
    end
  end

  // Blink phase: lamps lit for the first half-period after entering FL.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink <= 1'b0;
    end else if ((state_nxt == ST_FL) && (state_q != ST_FL)) begin
      blink <= 1'b1;
    end else if ((state_q == ST_FL) && flash_tick) begin
      blink <= ~blink;
    end
  end

  // ------------------------------------------------------------------
  // FSM: output decode (Moore, registers only)
  // ------------------------------------------------------------------
  always_comb begin
    hw_lamp = LAMP_RED;
    cr_lamp = LAMP_RED;
    case (state_q)
      ST_HG: begin
        hw_lamp = LAMP_GREEN;
        cr_lamp = LAMP_RED;
      end
      ST_HY: begin
        hw_lamp = LAMP_YELLOW;
        cr_lamp = LAMP_RED;
      end
      ST_CG: begin
        hw_lamp = LAMP_RED;
        cr_lamp = LAMP_GREEN;
      end
      ST_CY: begin
        hw_lamp = LAMP_RED;
        cr_lamp = LAMP_YELLOW;
      end
      // Flashing yellow on the highway, flashing red on the country road.
      ST_FL: begin
        hw_lamp = '{red: 1'b0, yellow: blink, green: 1'b0};
        cr_lamp = '{red: blink, yellow: 1'b0, green: 1'b0};
      end
      // AR1, AR2 and the illegal code all show red both ways.
      default: begin
        hw_lamp = LAMP_RED;
        cr_lamp = LAMP_RED;
      end
    endcase
  end

  assign highway_light = hw_lamp;
  assign country_light = cr_lamp;
  assign state_o       = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Purpose : self-checking bench for traffic_light_ctrl against a cycle-count reference model.
// Latency : checks every cycle on the falling edge, after the rising edge has settled.
// Backpressure : none.
module tb_traffic_light_ctrl;

  localparam int LONG_W     = 7;
  localparam int SHORT_W    = 4;
  localparam int CLR_CYCLES = 2;
  localparam int FLASH_HALF = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               sensor_c;
  logic [LONG_W-1:0]  Timeout;
  logic [SHORT_W-1:0] timeout;
  logic               flash_mode;
  logic [2:0]         highway_light;
  logic [2:0]         country_light;
  logic [2:0]         state_o;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: phase number (0 HG, 1 HY, 2 AR1, 3 CG, 4 CY, 5 AR2,
  // 6 FL), number of completed cycles in the phase, and the history of
  // sensor samples taken on each rising edge since reset.
  int m_phase;
  int m_cnt;
  int s_hist[$];

  always #5 clk = ~clk;

  traffic_light_ctrl #(
    .LONG_W    (LONG_W),
    .SHORT_W   (SHORT_W),
    .CLR_CYCLES(CLR_CYCLES),
    .FLASH_HALF(FLASH_HALF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sensor_c     (sensor_c),
    .Timeout      (Timeout),
    .timeout      (timeout),
    .flash_mode   (flash_mode),
    .highway_light(highway_light),
    .country_light(country_light),
    .state_o      (state_o)
  );

  // Flash lamps are lit during even-numbered half-periods of the FL phase.
  function automatic bit flash_on(int cnt);
    return ((cnt / FLASH_HALF) % 2) == 0;
  endfunction

  function automatic logic [2:0] exp_hw(int ph, int cnt);
    case (ph)
      0:       return 3'b001;
      1:       return 3'b010;
      6:       return flash_on(cnt) ? 3'b010 : 3'b000;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_cr(int ph, int cnt);
    case (ph)
      3:       return 3'b001;
      4:       return 3'b010;
      6:       return flash_on(cnt) ? 3'b100 : 3'b000;
      default: return 3'b100;
    endcase
  endfunction

  task automatic check(string tag, logic [2:0] obs, logic [2:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic both_go;
    check("highway_light", highway_light, exp_hw(m_phase, m_cnt));
    check("country_light", country_light, exp_cr(m_phase, m_cnt));
    check("state_o", state_o, 3'(m_phase));
    // Independent safety rule: never a yellow/green lamp on both roads.
    both_go = (|highway_light[1:0]) && (|country_light[1:0]);
    check("conflict", {2'b00, both_go}, 3'b000);
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_cnt   = 0;
    s_hist.delete();
  endtask

  // One clock cycle: decide the model's next phase from the inputs as they
  // stand before the edge, advance past the edge, check on the falling edge.
  task automatic tick();
    int  s_used;
    int  dl;
    int  ds;
    int  nxt;
    bit  done_long;
    bit  done_short;
    bit  done_clr;
    bit  live;
    live = reset;
    nxt  = m_phase;
    if (live) begin
      // The FSM sees the sensor as it was sampled two edges ago.
      s_used     = (s_hist.size() >= 2) ? s_hist[s_hist.size()-2] : 0;
      dl         = (Timeout == '0) ? 1 : int'(Timeout);
      ds         = (timeout == '0) ? 1 : int'(timeout);
      done_long  = (m_cnt + 1) >= dl;
      done_short = (m_cnt + 1) >= ds;
      done_clr   = (m_cnt + 1) >= CLR_CYCLES;
      case (m_phase)
        0: if (done_long && (s_used != 0 || flash_mode)) nxt = 1;
        1: if (done_short) nxt = 2;
        2: if (done_clr) nxt = flash_mode ? 6 : 3;
        3: if (s_used == 0 || flash_mode || done_long) nxt = 4;
        4: if (done_short) nxt = 5;
        5: if (done_clr) nxt = flash_mode ? 6 : 0;
        default: if (!flash_mode) nxt = 5;
      endcase
      s_hist.push_back(int'(sensor_c));
      if (s_hist.size() > 4) void'(s_hist.pop_front());
    end
    @(posedge clk);
    if (live) begin
      if (nxt != m_phase) begin
        m_phase = nxt;
        m_cnt   = 0;
      end else begin
        m_cnt++;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  // Asynchronous reset pulse landing between clock edges.
  task automatic reset_pulse();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int r;
    reset      = 1'b0;
    sensor_c   = 1'b0;
    flash_mode = 1'b0;
    Timeout    = LONG_W'(10);
    timeout    = SHORT_W'(3);
    model_reset();

    // Reset state before any clock edge.
    #1 check_outputs();
    tick();
    tick();
    reset = 1'b1;

    // No country traffic: highway keeps green indefinitely.
    repeat (100) tick();

    // Continuous country traffic: two full cycles of the sequence.
    sensor_c = 1'b1;
    repeat (60) tick();

    // Country road empties after 4 cycles of country green.
    for (int i = 0; i < 60 && state_o != 3'd3; i++) tick();
    check("reach_cg", state_o, 3'd3);
    repeat (3) tick();
    sensor_c = 1'b0;
    tick();
    check("drop_edge1", state_o, 3'd3);
    tick();
    check("drop_edge2", state_o, 3'd3);
    tick();
    check("drop_edge3", state_o, 3'd4);
    tick();
    check("cy_cycle2", state_o, 3'd4);
    tick();
    check("cy_cycle3", state_o, 3'd4);
    tick();
    check("cy_to_ar2", state_o, 3'd5);
    repeat (10) tick();

    // Zero durations behave as one cycle.
    Timeout  = '0;
    timeout  = '0;
    sensor_c = 1'b1;
    repeat (40) tick();

    // Maintenance flash requested while the highway holds green.
    Timeout  = LONG_W'(10);
    timeout  = SHORT_W'(3);
    sensor_c = 1'b0;
    repeat (30) tick();
    flash_mode = 1'b1;
    repeat (40) tick();
    check("in_flash", state_o, 3'd6);
    flash_mode = 1'b0;
    repeat (20) tick();

    // Reset in the middle of country yellow.
    sensor_c = 1'b1;
    for (int i = 0; i < 80 && state_o != 3'd4; i++) tick();
    check("reach_cy", state_o, 3'd4);
    #2 reset = 1'b0;
    #1;
    check("rst_async_hw", highway_light, 3'b001);
    check("rst_async_cr", country_light, 3'b100);
    check("rst_async_st", state_o, 3'd0);
    model_reset();
    tick();
    reset = 1'b1;
    repeat (40) tick();

    // Randomised traffic, flash requests, timer changes and resets.
    repeat (1500) begin
      r = int'($urandom_range(0, 99));
      if (r < 20) sensor_c = 1'($urandom_range(0, 1));
      if (r == 50) flash_mode = ~flash_mode;
      if (r == 60 || r == 61) Timeout = LONG_W'($urandom_range(0, 12));
      if (r == 62) timeout = SHORT_W'($urandom_range(0, 5));
      if (r == 99) reset_pulse();
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
